scan_chain_ctrl: RTL and testbench
==================================

Name: scan_chain_ctrl

Overview:
Scan chain of CHAIN_LEN mux-D scan cells (D flip-flops with a shift/capture mux) plus the FSM that drives them. It sits directly upstream of the functional logic fed by q.
- In functional mode the chain acts as a plain parallel register.
- In test mode it accepts a serial pattern through a valid/ready handshake, captures one functional response, and unloads that response serially.

Parameters:
CHAIN_LEN, 8, number of scan cells; legal range >= 2; counter width is $clog2(CHAIN_LEN).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted at 0)
test_mode  input  1  1 = scan operation allowed; 0 = functional mode
func_d  input  CHAIN_LEN  functional data / capture source
q  output  CHAIN_LEN  chain contents; q[CHAIN_LEN-1] is the serial-out end
start  input  1  single-cycle request to begin a scan sequence
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse at the end of a completed sequence
scan_in  input  1  serial pattern bit, sent MSB first
scan_in_valid  input  1  scan_in is valid
scan_in_ready  output  1  chain accepts a bit this cycle
scan_out  output  1  serial output, always equal to q[CHAIN_LEN-1]
scan_out_valid  output  1  scan_out carries a meaningful bit this cycle
parity_out  output  1  XOR of unloaded bits; see Optional Feature

Behaviour:
- Reset (reset=0, async): q=0, state=IDLE, cnt=0, busy=0, done=0, scan_in_ready=0, scan_out_valid=0, parity_out=0. Outputs are registered or decoded from state only.
- IDLE:
  - test_mode=0: q <= func_d every cycle (1-cycle latency); start is ignored.
  - test_mode=1: q holds.
  - test_mode=1 and start=1: cnt <= 0, go to SHIFT on the next edge.
- SHIFT:
  - scan_in_ready=1.
  - Handshake = scan_in_valid & scan_in_ready. On a handshake: q <= {q[CHAIN_LEN-2:0], scan_in}, cnt++, and scan_out_valid=1 that cycle (outgoing bit = old q[CHAIN_LEN-1]).
  - No handshake: q and cnt hold.
  - Handshake with cnt == CHAIN_LEN-1: go to CAPTURE, cnt <= 0.
- CAPTURE: exactly one cycle. q <= func_d; scan_in_ready=0; go to UNLOAD.
- UNLOAD:
  - No backpressure: every cycle q <= {q[CHAIN_LEN-2:0], 1'b0}, scan_out_valid=1, cnt++.
  - After CHAIN_LEN cycles (cnt == CHAIN_LEN-1), go to DONE.
  - Bits emitted, in order: captured q[CHAIN_LEN-1] down to q[0].
- DONE: done=1 for exactly one cycle; q holds (all zeros); go to IDLE.
- Abort: test_mode=0 in any of SHIFT/CAPTURE/UNLOAD means:
  - next state = IDLE, cnt <= 0, q holds on that edge;
  - no done pulse; any handshake in that cycle is ignored (scan_in_ready forced 0).
- start while busy: ignored.
- start and test_mode falling in the same cycle: stay in IDLE.
- Async reset mid-sequence: immediate return to the reset values; the partial pattern is lost.
- cnt is never compared beyond CHAIN_LEN-1, so no wrap occurs.

Optional Feature:
Macro SCAN_PARITY_EN.
- Defined: parity register cleared on entry to UNLOAD, XOR-accumulated with each unloaded bit. parity_out presents the final value while done=1 and holds it until the next start. Reset clears it to 0.
- Undefined: no parity logic is built; parity_out is tied to 0. The port list is identical in both builds.

Test Plan:
1. Reset: reset=0 for 3 cycles mid-SHIFT -> q=0x00, busy=0, done=0, scan_in_ready=0 immediately; after release the FSM stays in IDLE.
2. Functional path: test_mode=0, func_d=0xA5 -> q=0xA5 one edge later; start=1 -> busy remains 0.
3. Full sequence (CHAIN_LEN=8), q preloaded to 0x5A:
   - test_mode=1, start, scan_in bits 1,0,1,1,0,0,1,0 with valid held high -> scan_out emits 0,1,0,1,1,0,1,0 and q=0xB2 after the 8th handshake.
   - func_d=0x3C at CAPTURE -> UNLOAD emits 0,0,1,1,1,1,0,0 over 8 cycles -> done is high the following cycle, then busy=0.
4. Backpressure: scan_in_valid alternating 1/0 during SHIFT -> only the 8 valid cycles are accepted, q=0xB2, and CAPTURE occurs right after the 8th accepted bit (16 SHIFT cycles total).
5. Abort: test_mode dropped after the 4th accepted bit -> next cycle IDLE, busy=0, no done pulse, q holds its 4-bit-shifted value.
6. SCAN_PARITY_EN defined: capture 0x3C -> parity_out=0 at done; capture 0x3D -> parity_out=1. With the macro undefined, parity_out stays 0 in both cases.

Source files
------------

// File: rtl/scan_chain_if.sv
// Handshake/bus bundle for scan_chain_ctrl: sequence control, serial in/out and parity.
// The tester drives the master side; the chain controller is the slave.
interface scan_chain_if;
   logic start;
   logic busy;
   logic done;
   logic scan_in;
   logic scan_in_valid;
   logic scan_in_ready;
   logic scan_out;
   logic scan_out_valid;
   logic parity_out;

   modport master (
      output start, scan_in, scan_in_valid,
      input  busy, done, scan_in_ready, scan_out, scan_out_valid, parity_out
   );

   modport slave (
      input  start, scan_in, scan_in_valid,
      output busy, done, scan_in_ready, scan_out, scan_out_valid, parity_out
   );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Mux-D scan chain of CHAIN_LEN cells with its shift/capture/unload sequencer.
// Optional unload parity accumulator is built only when SCAN_PARITY_EN is defined.
module scan_chain_ctrl #(
   parameter int CHAIN_LEN = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 test_mode,
   input  logic [CHAIN_LEN-1:0] func_d,
   output logic [CHAIN_LEN-1:0] q,
   scan_chain_if.slave          sif
);

   localparam int CNT_W = $clog2(CHAIN_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SHIFT   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_UNLOAD  = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   state_t               state_r;
   state_t               state_nxt_s;
   logic [CHAIN_LEN-1:0] q_r;
   logic [CNT_W-1:0]     cnt_r;
   logic                 hs_s;
   logic                 busy_s;
   logic                 done_s;
   logic                 ready_s;
   logic                 out_valid_s;

   // Dropping test_mode aborts the sequence, so the handshake is qualified by it too.
   assign hs_s = (state_r == ST_SHIFT) & test_mode & sif.scan_in_valid;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE:    if (test_mode && sif.start) state_nxt_s = ST_SHIFT;
                     else                        state_nxt_s = ST_IDLE;
         ST_SHIFT:   if (!test_mode)                      state_nxt_s = ST_IDLE;
                     else if (hs_s && cnt_r == CNT_LAST)  state_nxt_s = ST_CAPTURE;
                     else                                 state_nxt_s = ST_SHIFT;
         ST_CAPTURE: if (!test_mode) state_nxt_s = ST_IDLE;
                     else            state_nxt_s = ST_UNLOAD;
         ST_UNLOAD:  if (!test_mode)            state_nxt_s = ST_IDLE;
                     else if (cnt_r == CNT_LAST) state_nxt_s = ST_DONE;
                     else                        state_nxt_s = ST_UNLOAD;
         ST_DONE:    state_nxt_s = ST_IDLE;
         default:    state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode from state (ready/valid also gated by the abort condition)
   always_comb begin
      busy_s      = 1'b0;
      done_s      = 1'b0;
      ready_s     = 1'b0;
      out_valid_s = 1'b0;
      case (state_r)
         ST_IDLE:    busy_s = 1'b0;
         ST_SHIFT: begin
            busy_s      = 1'b1;
            ready_s     = test_mode;
            out_valid_s = hs_s;
         end
         ST_CAPTURE: busy_s = 1'b1;
         ST_UNLOAD: begin
            busy_s      = 1'b1;
            out_valid_s = test_mode;
         end
         ST_DONE: begin
            busy_s = 1'b1;
            done_s = 1'b1;
         end
         default:    busy_s = 1'b0;
      endcase
   end

   // Chain cells and bit counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_r   <= '0;
         cnt_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               cnt_r <= '0;
               if (!test_mode) q_r <= func_d;
               else            q_r <= q_r;
            end
            ST_SHIFT: begin
               if (!test_mode) begin
                  cnt_r <= '0;
               end else if (hs_s) begin
                  q_r   <= {q_r[CHAIN_LEN-2:0], sif.scan_in};
                  cnt_r <= (cnt_r == CNT_LAST) ? '0 : cnt_r + CNT_ONE;
               end else begin
                  q_r   <= q_r;
               end
            end
            ST_CAPTURE: begin
               cnt_r <= '0;
               if (test_mode) q_r <= func_d;
               else           q_r <= q_r;
            end
            ST_UNLOAD: begin
               if (!test_mode) begin
                  cnt_r <= '0;
               end else begin
                  q_r   <= {q_r[CHAIN_LEN-2:0], 1'b0};
                  cnt_r <= (cnt_r == CNT_LAST) ? '0 : cnt_r + CNT_ONE;
               end
            end
            ST_DONE:  cnt_r <= '0;
            default: begin
               q_r   <= '0;
               cnt_r <= '0;
            end
         endcase
      end
   end

`ifdef SCAN_PARITY_EN
   logic parity_r;

   function automatic logic parity_acc(input logic acc, input logic data_bit);
      return acc ^ data_bit;
   endfunction

   // Parity of unloaded bits; cleared at start and on entry to UNLOAD, held after DONE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         parity_r <= 1'b0;
      end else if (state_r == ST_IDLE && test_mode && sif.start) begin
         parity_r <= 1'b0;
      end else if (state_r == ST_CAPTURE && test_mode) begin
         parity_r <= 1'b0;
      end else if (state_r == ST_UNLOAD && test_mode) begin
         parity_r <= parity_acc(parity_r, q_r[CHAIN_LEN-1]);
      end else begin
         parity_r <= parity_r;
      end
   end

   assign sif.parity_out = parity_r;
`else
   assign sif.parity_out = 1'b0;
`endif

   assign q                  = q_r;
   assign sif.scan_out       = q_r[CHAIN_LEN-1];
   assign sif.busy           = busy_s;
   assign sif.done           = done_s;
   assign sif.scan_in_ready  = ready_s;
   assign sif.scan_out_valid = out_valid_s;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl (CHAIN_LEN=8) with a serial-output scoreboard.
module tb_scan_chain_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       test_mode;
   logic [7:0] func_d;
   logic [7:0] q;

   scan_chain_if sif ();

   scan_chain_ctrl #(.CHAIN_LEN(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .test_mode (test_mode),
      .func_d    (func_d),
      .q         (q),
      .sif       (sif)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   bit sb[$];

   task automatic chk1(input string tag, input logic obs, input logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   // One clock: score any serial output at the falling edge, then step past the rising edge.
   task automatic tick();
      bit exp_bit;
      @(negedge clk);
      if (sif.scan_out_valid === 1'b1) begin
         chk1("sb_has_entry", sb.size() != 0, 1'b1);
         if (sb.size() != 0) begin
            exp_bit = sb.pop_front();
            chk1("scan_out", sif.scan_out, exp_bit);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_seq(input logic [7:0] preload, input logic [7:0] pat,
                          input logic [7:0] cap, input bit bp);
      logic [7:0] m;
      int         accepted;
      int         shift_cycles;
      logic       v;
      logic       exp_par;
      sif.start = 1'b0; sif.scan_in_valid = 1'b0; test_mode = 1'b0; func_d = preload;
      tick();
      chk8("preload", q, preload);
      m = preload;
      test_mode = 1'b1; sif.start = 1'b1; func_d = cap;
      tick();
      sif.start = 1'b0;
      chk1("busy_shift", sif.busy, 1'b1);
      accepted = 0;
      shift_cycles = 0;
      while (accepted < 8 && shift_cycles < 40) begin
         v = bp ? shift_cycles[0] : 1'b1;
         sif.scan_in_valid = v;
         sif.scan_in = pat[7 - accepted];
         if (v) begin
            sb.push_back(m[7]);
            m = {m[6:0], pat[7 - accepted]};
            accepted++;
         end
         tick();
         shift_cycles++;
      end
      sif.scan_in_valid = 1'b0;
      chk8("shift_cycles", 8'(shift_cycles), bp ? 8'd16 : 8'd8);
      chk8("q_after_shift", q, pat);
      chk1("ready_in_capture", sif.scan_in_ready, 1'b0);
      for (int i = 7; i >= 0; i--) sb.push_back(cap[i]);
      tick();
      chk8("q_captured", q, cap);
      for (int i = 0; i < 8; i++) begin
         chk1("done_early", sif.done, 1'b0);
         tick();
      end
      chk1("done_pulse", sif.done, 1'b1);
      chk8("q_at_done", q, 8'h00);
`ifdef SCAN_PARITY_EN
      exp_par = ^cap;
`else
      exp_par = 1'b0;
`endif
      chk1("parity_at_done", sif.parity_out, exp_par);
      tick();
      chk1("done_cleared", sif.done, 1'b0);
      chk1("busy_after_done", sif.busy, 1'b0);
      chk1("sb_drained", sb.size() == 0, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, mismatched %0d", mismatched);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; test_mode = 1'b0; func_d = 8'h00;
      sif.start = 1'b0; sif.scan_in = 1'b0; sif.scan_in_valid = 1'b0;
      #2;
      chk8("reset_q", q, 8'h00);
      chk1("reset_busy", sif.busy, 1'b0);
      chk1("reset_done", sif.done, 1'b0);
      chk1("reset_ready", sif.scan_in_ready, 1'b0);
      chk1("reset_parity", sif.parity_out, 1'b0);
      tick(); tick();
      reset = 1'b1;

      // functional path, start ignored when test_mode low
      func_d = 8'hA5;
      tick();
      chk8("func_q", q, 8'hA5);
      sif.start = 1'b1;
      tick();
      chk1("func_start_ignored", sif.busy, 1'b0);
      sif.start = 1'b0;

      run_seq(8'h5A, 8'hB2, 8'h3C, 1'b0);
      run_seq(8'h5A, 8'hB2, 8'h3C, 1'b1);
      run_seq(8'h00, 8'h6D, 8'h3D, 1'b0);

      // abort after four accepted bits
      test_mode = 1'b0; func_d = 8'h5A;
      tick();
      test_mode = 1'b1; sif.start = 1'b1; func_d = 8'hFF;
      tick();
      sif.start = 1'b0;
      sif.scan_in_valid = 1'b1;
      sb.push_back(1'b0); sif.scan_in = 1'b1; tick();
      sb.push_back(1'b1); sif.scan_in = 1'b0; tick();
      sb.push_back(1'b0); sif.scan_in = 1'b1; tick();
      sb.push_back(1'b1); sif.scan_in = 1'b1; tick();
      chk8("abort_q_4bits", q, 8'hAB);
      test_mode = 1'b0;
      #1;
      chk1("abort_ready_low", sif.scan_in_ready, 1'b0);
      chk1("abort_no_out_valid", sif.scan_out_valid, 1'b0);
      tick();
      sif.scan_in_valid = 1'b0;
      chk1("abort_busy", sif.busy, 1'b0);
      chk1("abort_no_done", sif.done, 1'b0);
      chk8("abort_q_held", q, 8'hAB);
      test_mode = 1'b1;
      tick();
      chk1("abort_still_no_done", sif.done, 1'b0);
      chk1("abort_sb_drained", sb.size() == 0, 1'b1);

      // async reset mid-SHIFT
      test_mode = 1'b0; func_d = 8'h00;
      tick();
      test_mode = 1'b1; sif.start = 1'b1; func_d = 8'hC3;
      tick();
      sif.start = 1'b0; sif.scan_in_valid = 1'b1; sif.scan_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sb.push_back(1'b0);
         tick();
      end
      chk8("midshift_q", q, 8'h07);
      sif.scan_in_valid = 1'b0;
      reset = 1'b0;
      #1;
      chk8("midreset_q", q, 8'h00);
      chk1("midreset_busy", sif.busy, 1'b0);
      chk1("midreset_done", sif.done, 1'b0);
      chk1("midreset_ready", sif.scan_in_ready, 1'b0);
      tick(); tick(); tick();
      reset = 1'b1;
      tick(); tick();
      chk1("post_reset_idle", sif.busy, 1'b0);
      chk8("post_reset_q", q, 8'h00);
      chk1("post_reset_sb", sb.size() == 0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
